// File: rtl/chip8_pkg.sv
// Shared CHIP-8 constants: screen geometry, memory address width, draw FSM states.
package chip8_pkg;

    localparam int SCREEN_W   = 64;
    localparam int SCREEN_H   = 32;
    localparam int MEM_ADDR_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } draw_state_t;

endpackage

// File: rtl/chip8_sprite_mask.sv
// Places one sprite byte at columns x0..x0+7 of a 64-bit row, MSB leftmost.
// Define CHIP8_DRAW_WRAP_EN to wrap columns modulo 64 instead of clipping them.
module chip8_sprite_mask
    import chip8_pkg::*;
(
    input  logic [7:0]          sprite_byte,
    input  logic [5:0]          x0,
    output logic [SCREEN_W-1:0] mask
);

`ifdef CHIP8_DRAW_WRAP_EN
    logic [5:0] col;

    always_comb begin
        mask = '0;
        col  = '0;
        for (int j = 0; j < 8; j++) begin
            col       = x0 + 6'(j);
            mask[col] = sprite_byte[3'(7 - j)];
        end
    end
`else
    logic [6:0] col;

    // A carry into bit 6 means the column fell off the right edge.
    always_comb begin
        mask = '0;
        col  = '0;
        for (int j = 0; j < 8; j++) begin
            col = {1'b0, x0} + 7'(j);
            if (!col[6]) begin
                mask[col[5:0]] = sprite_byte[3'(7 - j)];
            end
        end
    end
`endif

endmodule

// File: rtl/chip8_draw_unit.sv
// DXYN / 00E0 engine: fetches sprite rows, XORs them into a 64x32 framebuffer, reports VF.
// Define CHIP8_DRAW_WRAP_EN for wrap-around drawing; the default build clips at the screen edges.
module chip8_draw_unit
    import chip8_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cls,
    input  logic [7:0]        x_in,
    input  logic [7:0]        y_in,
    input  logic [3:0]        n_in,
    input  logic [ADDR_W-1:0] i_in,
    output logic              busy,
    output logic              done,
    output logic              collision,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_read,
    input  logic [7:0]        mem_data_in,
    input  logic [4:0]        fb_rd_row,
    output logic [63:0]       fb_rd_data
);

    draw_state_t         state;
    logic [5:0]          x0;
    logic [4:0]          y0;
    logic [3:0]          n;
    logic [ADDR_W-1:0]   base;
    logic [4:0]          k;
    logic [4:0]          clr_row;
    logic [SCREEN_W-1:0] fb [SCREEN_H];

    logic [SCREEN_W-1:0] mask;
    logic [SCREEN_W-1:0] old_row;
    logic [4:0]          cur_row;
    logic [4:0]          k_next;
    logic                last_row;

    chip8_sprite_mask u_mask (
        .sprite_byte (mem_data_in),
        .x0          (x0),
        .mask        (mask)
    );

    assign cur_row    = y0 + k;
    assign k_next     = k + 5'd1;
    assign old_row    = fb[cur_row];
    assign fb_rd_data = fb[fb_rd_row];

`ifdef CHIP8_DRAW_WRAP_EN
    assign last_row = (k_next == {1'b0, n});
`else
    logic [5:0] next_row;

    // Stop as soon as the following row would land below the screen.
    assign next_row = {1'b0, y0} + {1'b0, k_next};
    assign last_row = (k_next == {1'b0, n}) || next_row[5];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            x0           <= '0;
            y0           <= '0;
            n            <= '0;
            base         <= '0;
            k            <= '0;
            clr_row      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            collision    <= 1'b0;
            mem_read     <= 1'b0;
            mem_addr_out <= '0;
            for (int r = 0; r < SCREEN_H; r++) begin
                fb[r] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cls) begin
                        state     <= ST_CLEAR;
                        clr_row   <= '0;
                        collision <= 1'b0;
                        busy      <= 1'b1;
                    end else if (start) begin
                        x0        <= x_in[5:0];
                        y0        <= y_in[4:0];
                        n         <= n_in;
                        base      <= i_in;
                        k         <= '0;
                        collision <= 1'b0;
                        busy      <= 1'b1;
                        if (n_in == 4'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= ST_ADDR;
                            mem_addr_out <= i_in;
                            mem_read     <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    fb[clr_row] <= '0;
                    clr_row     <= clr_row + 5'd1;
                    if (clr_row == 5'd31) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    mem_read <= 1'b0;
                    state    <= ST_DATA;
                end
                ST_DATA: begin
                    fb[cur_row] <= old_row ^ mask;
                    if (|(old_row & mask)) begin
                        collision <= 1'b1;
                    end
                    k <= k_next;
                    if (last_row) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state        <= ST_ADDR;
                        mem_addr_out <= base + ADDR_W'(k_next);
                        mem_read     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    mem_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_draw_unit.sv
// Randomized bench for chip8_draw_unit against a pixel-level reference model.
module tb_chip8_draw_unit;

    localparam int ADDR_W = 12;
`ifdef CHIP8_DRAW_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              cls;
    logic [7:0]        x_in;
    logic [7:0]        y_in;
    logic [3:0]        n_in;
    logic [ADDR_W-1:0] i_in;
    logic              busy;
    logic              done;
    logic              collision;
    logic [ADDR_W-1:0] mem_addr_out;
    logic              mem_read;
    logic [7:0]        mem_data_in;
    logic [4:0]        fb_rd_row;
    logic [63:0]       fb_rd_data;

    logic [7:0]  mem [4096];
    logic [63:0] model_fb [32];
    int          exp_addr[$];
    int          got_addr[$];
    int          exp_done_cyc;
    bit          exp_coll;
    int          checks = 0;
    int          failures = 0;

    chip8_draw_unit #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cls          (cls),
        .x_in         (x_in),
        .y_in         (y_in),
        .n_in         (n_in),
        .i_in         (i_in),
        .busy         (busy),
        .done         (done),
        .collision    (collision),
        .mem_addr_out (mem_addr_out),
        .mem_read     (mem_read),
        .mem_data_in  (mem_data_in),
        .fb_rd_row    (fb_rd_row),
        .fb_rd_data   (fb_rd_data)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous read memory
    always @(posedge clk) mem_data_in <= mem[mem_addr_out];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) model_fb[r] = '0;
    endtask

    task automatic model_cls();
        model_clear();
        exp_addr.delete();
        exp_coll     = 1'b0;
        exp_done_cyc = 33;
    endtask

    task automatic model_draw(input int x, input int y, input int n, input int i);
        int         row;
        int         col;
        int         addr;
        logic [7:0] b;
        exp_addr.delete();
        exp_coll = 1'b0;
        for (int k = 0; k < n; k++) begin
            row = (y % 32) + k;
            if (!WRAP && row >= 32) break;
            row  = row % 32;
            addr = (i + k) % 4096;
            exp_addr.push_back(addr);
            b = mem[addr];
            for (int j = 0; j < 8; j++) begin
                if (b[7 - j]) begin
                    col = (x % 64) + j;
                    if (WRAP) col = col % 64;
                    if (col < 64) begin
                        if (model_fb[row][col]) exp_coll = 1'b1;
                        model_fb[row][col] = ~model_fb[row][col];
                    end
                end
            end
        end
        exp_done_cyc = 2 * exp_addr.size() + 1;
    endtask

    task automatic check_fb(input string tag);
        for (int r = 0; r < 32; r++) begin
            fb_rd_row = 5'(r);
            #1;
            chk($sformatf("%s row%0d", tag, r), fb_rd_data, model_fb[r]);
        end
    endtask

    task automatic run_cmd(input string tag, input bit do_cls, input bit do_start,
                           input int x, input int y, input int n, input int i);
        int cyc;
        got_addr.delete();
        @(negedge clk);
        cls   = do_cls;
        start = do_start;
        x_in  = 8'(x);
        y_in  = 8'(y);
        n_in  = 4'(n);
        i_in  = ADDR_W'(i);
        @(negedge clk);
        cls   = 1'b0;
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 100) begin
            if (mem_read) got_addr.push_back(int'(mem_addr_out));
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done_cycle"}, 64'(cyc), 64'(exp_done_cyc));
        chk({tag, " busy_at_done"}, 64'(busy), 64'd1);
        chk({tag, " collision"}, 64'(collision), 64'(exp_coll));
        chk({tag, " fetch_count"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int a = 0; a < exp_addr.size() && a < got_addr.size(); a++)
            chk($sformatf("%s fetch%0d", tag, a), 64'(got_addr[a]), 64'(exp_addr[a]));
        @(negedge clk);
        chk({tag, " busy_after"}, 64'(busy), 64'd0);
        chk({tag, " done_after"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        cls       = 1'b0;
        x_in      = '0;
        y_in      = '0;
        n_in      = '0;
        i_in      = '0;
        fb_rd_row = '0;
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        mem[12'h050] = 8'hF0;
        for (int a = 0; a < 4; a++) mem[12'h300 + a] = 8'hFF;
        model_clear();

        @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset collision", 64'(collision), 64'd0);
        chk("reset mem_read", 64'(mem_read), 64'd0);
        chk("reset mem_addr", 64'(mem_addr_out), 64'd0);
        check_fb("reset");
        @(negedge clk);
        reset = 1'b0;

        model_draw(0, 0, 1, 12'h050);
        run_cmd("draw1", 1'b0, 1'b1, 0, 0, 1, 12'h050);
        check_fb("draw1");
        fb_rd_row = 5'd0;
        #1;
        chk("draw1 row0 literal", fb_rd_data, 64'h0000_0000_0000_000F);

        model_draw(0, 0, 1, 12'h050);
        run_cmd("draw2", 1'b0, 1'b1, 0, 0, 1, 12'h050);
        check_fb("draw2");
        chk("draw2 coll literal", 64'(collision), 64'd1);

        model_draw(60, 30, 4, 12'h300);
        run_cmd("edge", 1'b0, 1'b1, 60, 30, 4, 12'h300);
        check_fb("edge");

        model_cls();
        run_cmd("cls_start", 1'b1, 1'b1, 0, 0, 1, 12'h050);
        check_fb("cls_start");

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(7) == 0) begin
                model_cls();
                run_cmd($sformatf("rnd%0d cls", t), 1'b1, 1'($urandom_range(1)), 0, 0, 1, 0);
            end else begin
                int x = $urandom_range(255);
                int y = $urandom_range(255);
                int n = $urandom_range(15);
                int i = (t % 5 == 0) ? $urandom_range(4095, 4090) : $urandom_range(4095);
                model_draw(x, y, n, i);
                run_cmd($sformatf("rnd%0d draw", t), 1'b0, 1'b1, x, y, n, i);
            end
            check_fb($sformatf("rnd%0d", t));
        end

        // Ensure there is content, then reset during the first DATA cycle of an n=5 draw.
        model_draw(8, 3, 5, 12'h300);
        run_cmd("pre_reset", 1'b0, 1'b1, 8, 3, 5, 12'h300);
        @(negedge clk);
        x_in  = 8'd10;
        y_in  = 8'd5;
        n_in  = 4'd5;
        i_in  = 12'h100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        chk("midreset mem_read", 64'(mem_read), 64'd0);
        chk("midreset collision", 64'(collision), 64'd0);
        model_clear();
        check_fb("midreset");
        @(negedge clk);
        reset = 1'b0;

        model_draw(0, 0, 0, 12'h050);
        run_cmd("n0", 1'b0, 1'b1, 0, 0, 0, 12'h050);
        check_fb("n0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
